// File: rtl/intr_controller.sv
// Interrupt arbiter: synchronises IRQ lines into pending bits and presents one
// lowest-index, masked, globally-enabled request to the control unit until it is acked.
module intr_controller #(
  parameter int N_SRC       = 8,
  parameter int ID_W        = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic             MASK_WE,
  input  logic [N_SRC-1:0] MASK_DIN,
  input  logic             I_SET,
  input  logic             I_CLR,
  input  logic             INTR_ACK,
  input  logic             INTR_RET,
  output logic             INTR,
  output logic [ID_W-1:0]  INTR_ID,
  output logic             IE,
  output logic [N_SRC-1:0] PENDING,
  output logic             IN_SERVICE
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

  state_t           state, state_nxt;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] rise_q;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr_vec;
  logic [ID_W-1:0]  lowest_id;
  logic [ID_W-1:0]  id_nxt;
  logic             ack_take;
  logic             ie_nxt;

  // Edge detection is registered so a rise reaches PENDING SYNC_STAGES+1 edges after sampling.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      sync_q[0] <= IRQ;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  always_comb begin
    eligible  = PENDING & mask_q;
    lowest_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) lowest_id = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = INTR_ID;
    ack_take  = INTR_ACK && (state == ST_REQ);
    case (state)
      ST_IDLE: begin
        if (IE && |eligible) begin
          state_nxt = ST_REQ;
          id_nxt    = lowest_id;
        end
      end
      ST_REQ: begin
        // Ack takes precedence over a retract caused by IE drop or masking.
        if (INTR_ACK)                     state_nxt = ST_SERVICE;
        else if (!IE || !mask_q[INTR_ID]) state_nxt = ST_IDLE;
      end
      ST_SERVICE: begin
        if (INTR_RET) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    clr_vec = ack_take ? ({{(N_SRC-1){1'b0}}, 1'b1} << INTR_ID) : '0;
    ie_nxt  = IE;
    if (ack_take || I_CLR) ie_nxt = 1'b0;
    else if (I_SET)        ie_nxt = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      mask_q     <= '0;
      PENDING    <= '0;
      IE         <= 1'b0;
      INTR       <= 1'b0;
      INTR_ID    <= '0;
      IN_SERVICE <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (MASK_WE) mask_q <= MASK_DIN;
      PENDING    <= (PENDING & ~clr_vec) | rise_q;
      IE         <= ie_nxt;
      INTR       <= (state_nxt == ST_REQ);
      INTR_ID    <= id_nxt;
      IN_SERVICE <= (state_nxt == ST_SERVICE);
    end
  end

endmodule
